uart_report_tx: RTL and testbench

UART_REPORT_TX -- requirements
Module: uart_report_tx

---
 rtl/uart_report_tx_pkg.sv | 24 ++
 rtl/uart_report_tx_toggle_sync.sv | 27 ++
 rtl/uart_report_tx.sv | 138 +++++++++++++
 tb/tb_uart_report_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_report_tx_pkg.sv
// Shared constants, FSM encoding and checksum
// helper for the UART report transmitter.
package uart_report_tx_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         PKT_LEN      = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_B2,
    S_B1,
    S_B0,
    S_CHK
  } state_t;

  function automatic logic [7:0] pkt_chk(
    input logic [7:0]  hdr,
    input logic [23:0] p
  );
    return hdr ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

endpackage

// File: rtl/uart_report_tx_toggle_sync.sv
// Toggle synchronizer with edge detect; emits a
// one-cycle pulse per level change of i_toggle.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_toggle,
  output logic o_event
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_toggle};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_event = r_sync[SYNC_STAGES-1] ^ r_last;

endmodule

// File: rtl/uart_report_tx.sv
// Packs each synchronized receiver result into a
// 5-byte report and streams it to the UART sink.
module uart_report_tx
  import uart_report_tx_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done_toggle,
  input  logic [23:0] pass_percentage,
  output logic [7:0]  to_uart_data,
  output logic        to_uart_valid,
  input  logic        to_uart_ready,
  output logic        busy,
  output logic        overrun
);

  state_t      r_state, w_state_nx;
  logic [23:0] r_pend_val, w_pend_val_nx;
  logic [23:0] r_tx, w_tx_nx;
  logic        r_pend, w_pend_nx;
  logic        r_valid, w_valid_nx;
  logic [7:0]  r_data, w_data_nx;
  logic        r_ovr, w_ovr_nx;
  logic        w_event;
  logic        w_accept;
  logic        w_load;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_toggle(rx_done_toggle),
    .o_event (w_event)
  );

  assign w_accept = r_valid & to_uart_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pend_val <= '0;
      r_tx       <= '0;
      r_pend     <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pend_val <= w_pend_val_nx;
      r_tx       <= w_tx_nx;
      r_pend     <= w_pend_nx;
      r_valid    <= w_valid_nx;
      r_data     <= w_data_nx;
      r_ovr      <= w_ovr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_pend_val_nx = r_pend_val;
    w_tx_nx       = r_tx;
    w_pend_nx     = r_pend;
    w_valid_nx    = r_valid;
    w_data_nx     = r_data;
    w_ovr_nx      = r_ovr;
    w_load        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_load     = 1'b1;
          w_state_nx = S_HDR;
          w_valid_nx = 1'b1;
          w_data_nx  = HDR_BYTE;
        end
      end
      S_HDR: begin
        if (w_accept) begin
          w_state_nx = S_B2;
          w_data_nx  = r_tx[23:16];
        end
      end
      S_B2: begin
        if (w_accept) begin
          w_state_nx = S_B1;
          w_data_nx  = r_tx[15:8];
        end
      end
      S_B1: begin
        if (w_accept) begin
          w_state_nx = S_B0;
          w_data_nx  = r_tx[7:0];
        end
      end
      S_B0: begin
        if (w_accept) begin
          w_state_nx = S_CHK;
          w_data_nx  = pkt_chk(HDR_BYTE, r_tx);
        end
      end
      S_CHK: begin
        if (w_accept) begin
          if (r_pend) begin
            w_load     = 1'b1;
            w_state_nx = S_HDR;
            w_data_nx  = HDR_BYTE;
          end else begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
    if (w_load) begin
      w_tx_nx   = r_pend_val;
      w_pend_nx = 1'b0;
    end
    // a same-edge transfer frees the slot, so no drop
    if (w_event) begin
      w_pend_val_nx = pass_percentage;
      w_pend_nx     = 1'b1;
      if (r_pend && !w_load) w_ovr_nx = 1'b1;
    end
  end

  assign to_uart_data  = r_data;
  assign to_uart_valid = r_valid;
  assign busy          = (r_state != S_IDLE) | r_pend;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_uart_report_tx.sv
// Randomized self-checking bench for uart_report_tx
// against a byte-stream reference model.
module tb_uart_report_tx;
  import uart_report_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tog;
  logic [23:0] pp;
  logic        rdy = 1'b0;
  logic [7:0]  data;
  logic        valid, busy, ovr;

  logic        tog3, rdy3;
  logic [23:0] pp3;
  logic [7:0]  d3;
  logic        v3, b3, o3;

  always #20 clk = ~clk;

  uart_report_tx #(
    .HDR_BYTE(8'hA5),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .rx_done_toggle (tog),
    .pass_percentage(pp),
    .to_uart_data   (data),
    .to_uart_valid  (valid),
    .to_uart_ready  (rdy),
    .busy           (busy),
    .overrun        (ovr)
  );

  uart_report_tx #(
    .SYNC_STAGES(3)
  ) u_dut3 (
    .clk            (clk),
    .rst            (rst),
    .rx_done_toggle (tog3),
    .pass_percentage(pp3),
    .to_uart_data   (d3),
    .to_uart_valid  (v3),
    .to_uart_ready  (rdy3),
    .busy           (b3),
    .overrun        (o3)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;
  int         rmode = 0;
  int         scnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void push_pkt(input logic [23:0] p);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < PKT_LEN - 1; k++) begin
      if (k == 0) b = 8'hA5;
      else b = 8'((p >> (8 * (3 - k))) & 24'hFF);
      x = x ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(x);
  endfunction

  // 0: ready high, 1: 3-cycle stall per byte,
  // 2: random, other: ready low
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: rdy = 1'b1;
      1: begin
        if (!valid) begin
          rdy = 1'b0;
          scnt = 0;
        end else if (scnt == 3) begin
          rdy = 1'b1;
          scnt = 0;
        end else begin
          rdy = 1'b0;
          scnt++;
        end
      end
      2: rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
  end

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", valid, 1);
        check("hold_data", data, pd);
      end
      if (valid && rdy) begin
        check("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("byte", data, exp_q.pop_front());
        acc_cnt++;
      end
      pv = valid;
      pr = rdy;
      pd = data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle_p(input logic [23:0] p);
    @(posedge clk);
    #1;
    pp  = p;
    tog = ~tog;
  endtask

  task automatic wait_idle(input int maxc);
    int i = 0;
    while ((busy || valid) && i < maxc) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("idle_timeout", i < maxc, 1);
  endtask

  task automatic wait_acc(input int target);
    int i = 0;
    while (acc_cnt < target && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("acc_timeout", acc_cnt >= target, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, hi, base;
    logic [23:0] p, pb, pc, pd4;
    rst  = 1'b1;
    tog  = 1'b0;
    pp   = '0;
    tog3 = 1'b0;
    rdy3 = 1'b1;
    pp3  = '0;
    cyc(2);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    cyc(3);

    rmode = 0;
    push_pkt(24'h012345);
    toggle_p(24'h012345);
    lat = -1;
    hi  = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (hi == 0) lat = i;
        hi++;
      end else if (hi > 0) begin
        break;
      end
    end
    check("lat_s2", lat, 3);
    check("valid_run", hi, 5);
    wait_idle(50);
    check("q_empty_1", exp_q.size(), 0);

    rmode = 1;
    push_pkt(24'hFFFFFF);
    toggle_p(24'hFFFFFF);
    cyc(4);
    wait_idle(200);
    check("q_empty_2", exp_q.size(), 0);

    p = 24'($urandom);
    push_pkt(p);
    push_pkt(24'h000064);
    base = acc_cnt;
    toggle_p(p);
    wait_acc(base + 2);
    toggle_p(24'h000064);
    wait_acc(base + 5);
    @(negedge clk);
    #1;
    check("b2b_valid", valid, 1);
    check("b2b_hdr", data, 8'hA5);
    wait_idle(200);
    check("b2b_ovr", ovr, 0);
    check("q_empty_3", exp_q.size(), 0);

    rmode = 3;
    p = 24'($urandom);
    push_pkt(p);
    toggle_p(p);
    cyc(6);
    check("pkt_started", valid, 1);
    pb  = 24'($urandom);
    pc  = 24'($urandom);
    pd4 = 24'($urandom);
    toggle_p(pb);
    cyc(10);
    check("ovr_after_1", ovr, 0);
    toggle_p(pc);
    cyc(10);
    check("ovr_after_2", ovr, 1);
    toggle_p(pd4);
    cyc(10);
    push_pkt(pd4);
    rmode = 0;
    wait_idle(200);
    check("ovr_held", ovr, 1);
    check("q_empty_4", exp_q.size(), 0);

    rmode = 2;
    for (int n = 0; n < 20; n++) begin
      p = 24'($urandom);
      push_pkt(p);
      toggle_p(p);
      cyc(4);
      wait_idle(300);
      cyc($urandom_range(0, 3));
    end
    check("ovr_sticky", ovr, 1);
    check("q_empty_5", exp_q.size(), 0);

    rmode = 1;
    p = 24'($urandom);
    push_pkt(p);
    base = acc_cnt;
    toggle_p(p);
    wait_acc(base + 1);
    @(posedge clk);
    #1;
    check("b2_shown", data, p[23:16]);
    rst = 1'b1;
    tog = 1'b0;
    #1;
    check("rst_mid_valid", valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ovr", ovr, 0);
    check("rst_mid_data", data, 0);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    base = acc_cnt;
    cyc(40);
    check("no_bytes", acc_cnt, base);
    check("post_busy", busy, 0);

    rmode = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tog = 1'b1;
    p = 24'($urandom);
    pp = p;
    push_pkt(p);
    cyc(2);
    rst = 1'b0;
    base = acc_cnt;
    cyc(6);
    wait_idle(100);
    cyc(10);
    check("held_tog_bytes", acc_cnt - base, 5);
    check("q_empty_6", exp_q.size(), 0);

    @(posedge clk);
    #1;
    pp3  = 24'h123456;
    tog3 = 1'b1;
    lat  = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (v3) begin
        lat = i;
        break;
      end
    end
    check("lat_s3", lat, 4);
    check("s3_hdr", d3, 8'hA5);
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
